// File: rtl/row_access_seq.sv
// row_access_seq: row access sequencer for a 64-row SRAM-style array.
// Steps each accepted request through precharge, wordline, optional sense
// and done phases, driving the row address to the 6-to-64 decoder.
//
// Parameters:
//   T_PRE  precharge phase length in cycles (1..15)
//   T_WL   wordline phase length in cycles (1..15)
//
// Ports:
//   clk        single clock, rising edge
//   rst_n      synchronous active-low reset
//   req_valid  request present
//   req_ready  block can accept a request (IDLE only)
//   req_addr   target row
//   req_we     1 = write, 0 = read
//   req_len    burst length minus 1 (used only with ROW_SEQ_BURST_EN)
//   row_addr   registered row to decoder in_addr
//   pre_n      bitline precharge, active-low
//   wl_en      wordline enable
//   sae        sense-amp enable (reads)
//   wr_en      write-driver enable (writes)
//   busy       access in progress
//   done       one-cycle pulse at the end of each row access
//
// Configuration macro:
//   ROW_SEQ_BURST_EN  when defined, each request performs req_len+1
//                     consecutive row accesses; otherwise exactly one.

module row_access_seq #(
  parameter int unsigned T_PRE = 1,
  parameter int unsigned T_WL  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [5:0] req_addr,
  input  logic       req_we,
  input  logic [2:0] req_len,
  output logic [5:0] row_addr,
  output logic       pre_n,
  output logic       wl_en,
  output logic       sae,
  output logic       wr_en,
  output logic       busy,
  output logic       done
);

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned LEN_W  = 3;

  localparam logic [CNT_W-1:0] PRE_LOAD = CNT_W'(T_PRE - 1);
  localparam logic [CNT_W-1:0] WL_LOAD  = CNT_W'(T_WL - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRE   = 3'd1,
    WL    = 3'd2,
    SENSE = 3'd3,
    DONE  = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   row_addr_q, row_addr_d;
  logic                we_q, we_d;
  logic                req_ready_q, req_ready_d;
  logic                pre_n_q, pre_n_d;
  logic                wl_en_q, wl_en_d;
  logic                sae_q, sae_d;
  logic                wr_en_q, wr_en_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                accept_c;
  logic                last_access_c;

`ifdef ROW_SEQ_BURST_EN
  logic [LEN_W-1:0]    burst_q, burst_d;
`else
  // req_len has no function without burst support.
  logic                unused_req_len_c;
  assign unused_req_len_c = ^req_len;
`endif

  assign accept_c = req_valid && req_ready_q;

`ifdef ROW_SEQ_BURST_EN
  assign last_access_c = (burst_q == LEN_W'(0));
`else
  assign last_access_c = 1'b1;
`endif

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    row_addr_d = row_addr_q;
    we_d       = we_q;
`ifdef ROW_SEQ_BURST_EN
    burst_d    = burst_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (accept_c) begin
          row_addr_d = req_addr;
          we_d       = req_we;
`ifdef ROW_SEQ_BURST_EN
          burst_d    = req_len;
`endif
          cnt_d      = PRE_LOAD;
          state_d    = PRE;
        end
      end
      PRE: begin
        if (cnt_q == CNT_W'(0)) begin
          cnt_d   = WL_LOAD;
          state_d = WL;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      WL: begin
        if (cnt_q == CNT_W'(0)) begin
          cnt_d   = CNT_W'(0);
          state_d = we_q ? DONE : SENSE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      SENSE: begin
        state_d = DONE;
      end
      DONE: begin
        if (last_access_c) begin
          state_d = IDLE;
        end else begin
          // Next row of the burst; 6-bit add wraps 63 -> 0.
          row_addr_d = row_addr_q + ADDR_W'(1);
`ifdef ROW_SEQ_BURST_EN
          burst_d    = burst_q - LEN_W'(1);
`endif
          cnt_d      = PRE_LOAD;
          state_d    = PRE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they register in step
    // with the state they describe.
    req_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
    pre_n_d     = (state_d != PRE);
    wl_en_d     = (state_d == WL);
    wr_en_d     = (state_d == WL) && we_d;
    sae_d       = (state_d == SENSE);
    done_d      = (state_d == DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      row_addr_q  <= '0;
      we_q        <= 1'b0;
      req_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      pre_n_q     <= 1'b1;
      wl_en_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      sae_q       <= 1'b0;
      done_q      <= 1'b0;
`ifdef ROW_SEQ_BURST_EN
      burst_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      row_addr_q  <= row_addr_d;
      we_q        <= we_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
      pre_n_q     <= pre_n_d;
      wl_en_q     <= wl_en_d;
      wr_en_q     <= wr_en_d;
      sae_q       <= sae_d;
      done_q      <= done_d;
`ifdef ROW_SEQ_BURST_EN
      burst_q     <= burst_d;
`endif
    end
  end

  assign req_ready = req_ready_q;
  assign busy      = busy_q;
  assign row_addr  = row_addr_q;
  assign pre_n     = pre_n_q;
  assign wl_en     = wl_en_q;
  assign wr_en     = wr_en_q;
  assign sae       = sae_q;
  assign done      = done_q;

  // Electrical safety: never precharge into an open wordline, never sense
  // while the write drivers are on.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(!pre_n_q && wl_en_q));
      assert (!(sae_q && wr_en_q));
    end
  end

endmodule

// File: tb/tb_row_access_seq.sv
// tb_row_access_seq: directed self-checking bench for row_access_seq with
// default timing (T_PRE=1, T_WL=2). Sample k means #1 after the k-th rising
// edge following the accept edge.

module tb_row_access_seq;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [5:0] req_addr;
  logic       req_we;
  logic [2:0] req_len;
  logic [5:0] row_addr;
  logic       pre_n;
  logic       wl_en;
  logic       sae;
  logic       wr_en;
  logic       busy;
  logic       done;

  int total;
  int bad;

  row_access_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_we    (req_we),
    .req_len   (req_len),
    .row_addr  (row_addr),
    .pre_n     (pre_n),
    .wl_en     (wl_en),
    .sae       (sae),
    .wr_en     (wr_en),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bounded wait for the block to return to IDLE.
  task automatic wait_idle();
    int n;
    n = 0;
    while (!req_ready && n < 60) begin
      tick();
      n++;
    end
    total++;
    if (req_ready !== 1'b1) begin
      bad++;
      $display("FAIL wait_idle timeout got_ready=%b exp=1", req_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b1; req_addr = 6'd17; req_we = 1'b0; req_len = 3'd0;
    tick();
    tick();
    total++;
    if ({row_addr, pre_n, wl_en, sae, wr_en, busy, done} !== {6'd0, 1'b1, 5'b00000}) begin
      bad++;
      $display("FAIL reset_vals got row=%0d pre_n=%b wl=%b sae=%b wr=%b busy=%b done=%b exp row=0 pre_n=1 others=0",
               row_addr, pre_n, wl_en, sae, wr_en, busy, done);
    end
    req_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    total++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_release got ready=%b busy=%b exp ready=1 busy=0", req_ready, busy);
    end
  endtask

  task automatic test_single_read();
    logic exp_pre_n, exp_wl, exp_sae, exp_done;
    req_valid = 1'b1; req_addr = 6'd10; req_we = 1'b0; req_len = 3'd0;
    tick();
    req_valid = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      exp_pre_n = (c != 1);
      exp_wl    = (c == 2 || c == 3);
      exp_sae   = (c == 4);
      exp_done  = (c == 5);
      total++;
      if (pre_n !== exp_pre_n || wl_en !== exp_wl || sae !== exp_sae || done !== exp_done || wr_en !== 1'b0) begin
        bad++;
        $display("FAIL rd_phase c=%0d got pre_n=%b wl=%b sae=%b done=%b wr=%b exp pre_n=%b wl=%b sae=%b done=%b wr=0",
                 c, pre_n, wl_en, sae, done, wr_en, exp_pre_n, exp_wl, exp_sae, exp_done);
      end
      total++;
      if (row_addr !== 6'd10) begin
        bad++;
        $display("FAIL rd_row c=%0d got=%0d exp=10", c, row_addr);
      end
      total++;
      if (req_ready !== (c == 6) || busy !== (c != 6)) begin
        bad++;
        $display("FAIL rd_ready c=%0d got ready=%b busy=%b exp ready=%b", c, req_ready, busy, (c == 6));
      end
      tick();
    end
  endtask

  task automatic test_single_write();
    logic exp_wl, exp_done, saw_sae;
    saw_sae = 1'b0;
    wait_idle();
    req_valid = 1'b1; req_addr = 6'd63; req_we = 1'b1; req_len = 3'd0;
    tick();
    req_valid = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      exp_wl   = (c == 2 || c == 3);
      exp_done = (c == 4);
      if (sae) saw_sae = 1'b1;
      total++;
      if (wl_en !== exp_wl || wr_en !== exp_wl || done !== exp_done || pre_n !== (c != 1)) begin
        bad++;
        $display("FAIL wr_phase c=%0d got wl=%b wr=%b done=%b pre_n=%b exp wl=%b wr=%b done=%b pre_n=%b",
                 c, wl_en, wr_en, done, pre_n, exp_wl, exp_wl, exp_done, (c != 1));
      end
      total++;
      if (row_addr !== 6'd63) begin
        bad++;
        $display("FAIL wr_row c=%0d got=%0d exp=63", c, row_addr);
      end
      if (c < 5) tick();
    end
    total++;
    if (saw_sae !== 1'b0 || req_ready !== 1'b1) begin
      bad++;
      $display("FAIL wr_end got saw_sae=%b ready=%b exp saw_sae=0 ready=1", saw_sae, req_ready);
    end
  endtask

  task automatic test_reset_mid_wl();
    wait_idle();
    req_valid = 1'b1; req_addr = 6'd5; req_we = 1'b0; req_len = 3'd0;
    tick();
    tick();
    total++;
    if (wl_en !== 1'b1) begin
      bad++;
      $display("FAIL mid_wl_pre got wl=%b exp=1", wl_en);
    end
    // req_valid stays high through reset: nothing may be accepted.
    rst_n = 1'b0;
    tick();
    total++;
    if (wl_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || pre_n !== 1'b1 || row_addr !== 6'd0) begin
      bad++;
      $display("FAIL mid_wl_rst got wl=%b busy=%b done=%b pre_n=%b row=%0d exp wl=0 busy=0 done=0 pre_n=1 row=0",
               wl_en, busy, done, pre_n, row_addr);
    end
    tick();
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL mid_wl_noacc got busy=%b done=%b exp 0 0", busy, done);
    end
    req_valid = 1'b0;
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      total++;
      if (done !== 1'b0 || req_ready !== 1'b1) begin
        bad++;
        $display("FAIL mid_wl_after c=%0d got done=%b ready=%b exp done=0 ready=1", c, done, req_ready);
      end
    end
  endtask

  task automatic test_reset_traffic();
    wait_idle();
    for (int c = 0; c < 7; c++) begin
      req_valid = 1'($urandom_range(0, 1));
      req_addr  = 6'($urandom);
      req_we    = 1'($urandom_range(0, 1));
      req_len   = 3'($urandom);
      tick();
    end
    rst_n = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      total++;
      if ({row_addr, pre_n, wl_en, sae, wr_en, busy, done} !== {6'd0, 1'b1, 5'b00000}) begin
        bad++;
        $display("FAIL traffic_rst c=%0d got row=%0d pre_n=%b wl=%b sae=%b wr=%b busy=%b done=%b exp row=0 pre_n=1 others=0",
                 c, row_addr, pre_n, wl_en, sae, wr_en, busy, done);
      end
    end
    req_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    total++;
    if (req_ready !== 1'b1) begin
      bad++;
      $display("FAIL traffic_release got ready=%b exp=1", req_ready);
    end
  endtask

  task automatic test_back_to_back();
    wait_idle();
    req_valid = 1'b1; req_addr = 6'd20; req_we = 1'b1; req_len = 3'd0;
    tick();
    req_addr = 6'd21;
    for (int c = 1; c <= 4; c++) begin
      total++;
      if (row_addr !== 6'd20 || req_ready !== 1'b0) begin
        bad++;
        $display("FAIL b2b_first c=%0d got row=%0d ready=%b exp row=20 ready=0", c, row_addr, req_ready);
      end
      tick();
    end
    total++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || row_addr !== 6'd20) begin
      bad++;
      $display("FAIL b2b_idle got ready=%b busy=%b row=%0d exp ready=1 busy=0 row=20", req_ready, busy, row_addr);
    end
    tick();
    req_valid = 1'b0;
    total++;
    if (busy !== 1'b1 || pre_n !== 1'b0 || row_addr !== 6'd21) begin
      bad++;
      $display("FAIL b2b_second got busy=%b pre_n=%b row=%0d exp busy=1 pre_n=0 row=21", busy, pre_n, row_addr);
    end
    wait_idle();
  endtask

`ifdef ROW_SEQ_BURST_EN
  task automatic test_burst();
    logic [5:0] exp_row;
    wait_idle();
    req_valid = 1'b1; req_addr = 6'd62; req_we = 1'b0; req_len = 3'd3;
    tick();
    req_valid = 1'b0;
    for (int c = 1; c <= 21; c++) begin
      exp_row = (c == 21) ? 6'd1 : 6'(62 + (c - 1) / 5);
      total++;
      if (row_addr !== exp_row) begin
        bad++;
        $display("FAIL burst_row c=%0d got=%0d exp=%0d", c, row_addr, exp_row);
      end
      total++;
      if (done !== (c <= 20 && c % 5 == 0) || sae !== (c <= 20 && c % 5 == 4) || pre_n !== !(c <= 20 && c % 5 == 1)) begin
        bad++;
        $display("FAIL burst_phase c=%0d got done=%b sae=%b pre_n=%b", c, done, sae, pre_n);
      end
      total++;
      if (req_ready !== (c == 21)) begin
        bad++;
        $display("FAIL burst_ready c=%0d got=%b exp=%b", c, req_ready, (c == 21));
      end
      tick();
    end
  endtask
`else
  task automatic test_no_burst();
    int n_done;
    n_done = 0;
    wait_idle();
    req_valid = 1'b1; req_addr = 6'd30; req_we = 1'b0; req_len = 3'd5;
    tick();
    req_valid = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      if (done) n_done++;
      tick();
    end
    total++;
    if (n_done !== 1 || row_addr !== 6'd30 || req_ready !== 1'b1) begin
      bad++;
      $display("FAIL no_burst got done_cnt=%0d row=%0d ready=%b exp done_cnt=1 row=30 ready=1",
               n_done, row_addr, req_ready);
    end
  endtask
`endif

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_addr = '0;
    req_we = 1'b0;
    req_len = '0;
    test_reset();
    test_single_read();
    test_single_write();
    test_reset_mid_wl();
    test_back_to_back();
`ifdef ROW_SEQ_BURST_EN
    test_burst();
`else
    test_no_burst();
`endif
    test_reset_traffic();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/row_access_seq.md
ROW_ACCESS_SEQ -- requirements
Module: row_access_seq

Interface
Parameters
REQ-001 SHALL provide T_PRE, default 1, precharge phase length in cycles (legal 1..15).
REQ-002 SHALL provide T_WL, default 2, wordline phase length in cycles (legal 1..15).

Ports
REQ-003 SHALL have clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have rst_n, input, 1, reset: synchronous, active-low.
REQ-005 SHALL have req_valid, input, 1, request present.
REQ-006 SHALL have req_ready, output, 1, block can accept a request.
REQ-007 SHALL have req_addr, input, 6, target row.
REQ-008 SHALL have req_we, input, 1, 1 = write, 0 = read.
REQ-009 SHALL have req_len, input, 3, burst length minus 1.
REQ-010 SHALL have row_addr, output, 6, registered row driven to the 6-to-64 decoder in_addr.
REQ-011 SHALL have pre_n, output, 1, bitline precharge, active-low.
REQ-012 SHALL have wl_en, output, 1, wordline enable.
REQ-013 SHALL have sae, output, 1, sense-amp enable (reads only).
REQ-014 SHALL have wr_en, output, 1, write-driver enable (writes only).
REQ-015 SHALL have busy, output, 1, access in progress (state not IDLE).
REQ-016 SHALL have done, output, 1, one-cycle pulse at the end of each row access.

Function
REQ-017 SHALL implement the FSM states IDLE, PRE, WL, SENSE, DONE.
REQ-018 SHALL assert req_ready only in IDLE, and SHALL accept a request on an edge where req_valid and req_ready are both 1.
  - On accept: capture req_addr into row_addr, and capture req_we and req_len.
  - Next state: PRE.
REQ-019 SHALL hold pre_n=0 in PRE for T_PRE cycles, then go to WL.
REQ-020 SHALL hold wl_en=1 in WL for T_WL cycles.
  - wr_en SHALL equal the captured we throughout WL.
  - Exit to SENSE on a read, to DONE on a write.
REQ-021 SHALL assert sae=1 for exactly one cycle in SENSE, then go to DONE.
REQ-022 SHALL assert done=1 for one cycle in DONE.
  - Remaining burst count 0: next state IDLE.
  - Otherwise: row_addr = row_addr + 1 mod 64 (63 wraps to 0), decrement count, next state PRE.
REQ-023 SHALL keep row_addr stable from PRE through DONE; in IDLE it SHALL hold the last accessed row.
REQ-024 SHALL never assert pre_n=0 and wl_en=1 together, and SHALL never assert sae and wr_en together.
REQ-025 SHALL ignore req_valid outside IDLE, with no queuing.
REQ-026 SHALL meet the single-access latency with defaults, counting the accept edge as cycle 0:
  - Read: done in cycle 5.
  - Write: done in cycle 4.
  - req_ready=1 in the cycle after done.
REQ-027 SHALL keep its timing counters 4 bits wide, with no overflow for legal parameters.

Reset
REQ-028 SHALL, on any edge with rst_n=0, force state IDLE and the following values:
  - row_addr=0, pre_n=1, wl_en=0, sae=0, wr_en=0, busy=0, done=0.
  - Burst count cleared.
REQ-029 SHALL drop an in-flight access on reset mid-operation, with no done pulse.
REQ-030 SHALL not accept any request on an edge where rst_n=0.
REQ-031 SHALL drive req_ready=1 from the first cycle after rst_n returns high.

Configuration
REQ-032 SHALL gate burst support on macro ROW_SEQ_BURST_EN.
  - Defined: req_len+1 consecutive row accesses per request, per REQ-022.
  - Undefined: req_len ignored, exactly one access per request, and the burst counter SHALL be absent.

Verification
REQ-033 SHALL cover reset: rst_n=0 for 2 cycles during random traffic -> all outputs at REQ-028 values; req_ready=1 after release.
REQ-034 SHALL cover a single read, addr=10, defaults, accepted at cycle 0:
  - pre_n=0 in cycle 1; wl_en=1 in cycles 2-3; sae=1 in cycle 4; done=1 in cycle 5.
  - row_addr=10 in cycles 1-5.
REQ-035 SHALL cover a single write, addr=63: wl_en=wr_en=1 in cycles 2-3, sae never asserted, done in cycle 4.
REQ-036 SHALL cover a burst read with ROW_SEQ_BURST_EN, addr=62, len=3:
  - Rows 62, 63, 0, 1, each a full PRE/WL/SENSE/DONE sequence.
  - 4 done pulses; req_ready low until after the last.
REQ-037 SHALL cover reset mid-WL: rst_n=0 while wl_en=1 -> wl_en=0 at the next edge, no done, state IDLE.
REQ-038 SHALL cover back-to-back and no-burst cases:
  - req_valid held high -> second request accepted in the first IDLE cycle.
  - Without the macro, len=5 -> exactly 1 done pulse.
